// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Turns one raw, bouncing push-button input into clean level and event
// signals in the i_CLK domain. The button is first polarity-normalised
// (pressed = 1) and synchronised through SYNC_STAGES flops. A four-state
// debounce FSM then accepts a press or release only after DEBOUNCE_CYCLES
// consecutive stable samples. While the button is held, a hold timer
// produces a one-shot long-press event after LONG_CYCLES cycles.
//
// Optional feature (compile-time macro BTN_DEBOUNCE_AUTOREPEAT_EN):
//   when defined, o_press re-pulses every REPEAT_CYCLES cycles after o_long
//   while the button stays held. The repeat timer reuses the hold counter.
//   When undefined, exactly one o_press is produced per accepted press and
//   no repeat logic exists.
//
// Parameters:
//   SYNC_STAGES     synchroniser depth (>= 2)
//   DEBOUNCE_CYCLES stable cycles needed to accept a press/release (>= 2)
//   LONG_CYCLES     cycles from o_press to o_long (>= 2)
//   REPEAT_CYCLES   auto-repeat period, optional feature only (>= 2)
//   IN_ACTIVE_LOW   1 = raw button reads 0 when pressed
//
// Ports:
//   i_CLK      in   system clock
//   i_RST_N    in   asynchronous active-low reset
//   i_btn      in   raw asynchronous button
//   o_level    out  debounced pressed level (HELD or RELEASE_CHK)
//   o_press    out  one-cycle pulse on accepted press (and auto-repeat)
//   o_release  out  one-cycle pulse on accepted release
//   o_long     out  one-cycle pulse when the hold reaches LONG_CYCLES
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int LONG_CYCLES     = 12000000,
   parameter int REPEAT_CYCLES   = 1200000,
   parameter int IN_ACTIVE_LOW   = 0
) (
   input  logic i_CLK,
   input  logic i_RST_N,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long
);

   // ------------------------------------------------------------------
   // Counter widths and terminal values
   // ------------------------------------------------------------------
   localparam int HOLD_MAX   = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W_RAW  = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W_RAW = $clog2(HOLD_MAX);
   localparam int CNT_W      = (CNT_W_RAW  < 1) ? 1 : CNT_W_RAW;
   localparam int HOLD_W     = (HOLD_W_RAW < 1) ? 1 : HOLD_W_RAW;

   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
   localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
   localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYCLES - 1);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
   localparam logic [HOLD_W-1:0] HOLD_REP  = HOLD_W'(REPEAT_CYCLES - 1);
`endif

   // ------------------------------------------------------------------
   // FSM encoding
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_RELEASED    = 2'd0,
      ST_PRESS_CHK   = 2'd1,
      ST_HELD        = 2'd2,
      ST_RELEASE_CHK = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------
   // Stability counter step. The FSM leaves the check state on the terminal
   // value, so the counter never needs to wrap; holding at CNT_LAST keeps it
   // safe even if the state were ever corrupted.
   function automatic logic [CNT_W-1:0] stab_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == CNT_LAST) begin
         r = v;
      end else begin
         r = v + CNT_ONE;
      end
      return r;
   endfunction

   // Hold counter step, saturating at the given limit.
   function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] v,
                                                  input logic [HOLD_W-1:0] lim);
      logic [HOLD_W-1:0] r;
      if (v >= lim) begin
         r = lim;
      end else begin
         r = v + HOLD_ONE;
      end
      return r;
   endfunction

   // ------------------------------------------------------------------
   // Input polarity normalisation and synchroniser
   // ------------------------------------------------------------------
   logic                   btn_norm_s;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   sync_s;

   // Normalise so that 1 always means "pressed" downstream.
   always_comb begin
      if (IN_ACTIVE_LOW != 0) begin
         btn_norm_s = ~i_btn;
      end else begin
         btn_norm_s = i_btn;
      end
   end

   // Next value of the synchroniser shift chain (new sample enters bit 0).
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], btn_norm_s};
   end

   // Synchroniser flops; cleared to "not pressed" on reset.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         sync_q <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Debounce FSM, stability counter, hold timer and registered outputs
   // ------------------------------------------------------------------
   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [HOLD_W-1:0] hold_q;
   logic              long_fired_q;
   logic              level_q;
   logic              press_q;
   logic              release_q;
   logic              long_q;

   // Debounce state machine; all decisions use the synchronised sample.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_q      <= ST_RELEASED;
         cnt_q        <= CNT_ZERO;
         hold_q       <= HOLD_ZERO;
         long_fired_q <= 1'b0;
         level_q      <= 1'b0;
         press_q      <= 1'b0;
         release_q    <= 1'b0;
         long_q       <= 1'b0;
      end else begin
         // Event outputs are single-cycle pulses unless re-asserted below.
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;

         case (state_q)
            ST_RELEASED: begin
               if (sync_s) begin
                  state_q <= ST_PRESS_CHK;
                  cnt_q   <= CNT_ZERO;
               end else begin
                  state_q <= ST_RELEASED;
               end
            end

            ST_PRESS_CHK: begin
               if (!sync_s) begin
                  // Bounce: drop back without any output.
                  state_q <= ST_RELEASED;
               end else if (cnt_q == CNT_LAST) begin
                  state_q      <= ST_HELD;
                  press_q      <= 1'b1;
                  level_q      <= 1'b1;
                  hold_q       <= HOLD_ZERO;
                  long_fired_q <= 1'b0;
               end else begin
                  cnt_q <= stab_inc(cnt_q);
               end
            end

            ST_HELD: begin
               if (!sync_s) begin
                  // Possible release; the hold timer stays frozen meanwhile.
                  state_q <= ST_RELEASE_CHK;
                  cnt_q   <= CNT_ZERO;
               end else if (!long_fired_q) begin
                  if (hold_q == HOLD_LONG) begin
                     long_q       <= 1'b1;
                     long_fired_q <= 1'b1;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                     // Counter is reused as the repeat timer from here on.
                     hold_q       <= HOLD_ZERO;
`endif
                  end else begin
                     hold_q <= hold_inc(hold_q, HOLD_LONG);
                  end
               end else begin
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                  if (hold_q == HOLD_REP) begin
                     press_q <= 1'b1;
                     hold_q  <= HOLD_ZERO;
                  end else begin
                     hold_q <= hold_inc(hold_q, HOLD_REP);
                  end
`else
                  // Long press already reported; counter rests saturated.
                  hold_q <= hold_inc(hold_q, HOLD_LONG);
`endif
               end
            end

            ST_RELEASE_CHK: begin
               if (sync_s) begin
                  // Release glitch: resume holding, keep hold timer and flag.
                  state_q <= ST_HELD;
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= ST_RELEASED;
                  release_q <= 1'b1;
                  level_q   <= 1'b0;
               end else begin
                  cnt_q <= stab_inc(cnt_q);
               end
            end

            default: begin
               // Unreachable encoding: recover to a known safe state.
               state_q      <= ST_RELEASED;
               cnt_q        <= CNT_ZERO;
               hold_q       <= HOLD_ZERO;
               long_fired_q <= 1'b0;
               level_q      <= 1'b0;
            end
         endcase
      end
   end

   assign o_level   = level_q;
   assign o_press   = press_q;
   assign o_release = release_q;
   assign o_long    = long_q;

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Conditions one raw push-button input into clean, single-clock-domain level and event signals.
- Sits directly upstream of the counter/LED top-level and drives its reset/step inputs.
- Stages: SYNC_STAGES-deep synchroniser, debounce FSM with stability counter, and hold timer for long-press detection.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (≥2).
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a press or release (≥2).
- LONG_CYCLES, 12000000, cycles from o_press to o_long (≥2).
- REPEAT_CYCLES, 1200000, auto-repeat period; used only with the optional feature (≥2).
- IN_ACTIVE_LOW, 0, 1 = raw button reads 0 when pressed.

Ports:
- i_CLK  in  1  single system clock
- i_RST_N  in  1  asynchronous, active-low reset
- i_btn  in  1  raw, asynchronous, bouncing button
- o_level  out  1  debounced pressed level
- o_press  out  1  one-cycle pulse on accepted press (and auto-repeat)
- o_release  out  1  one-cycle pulse on accepted release
- o_long  out  1  one-cycle pulse when hold reaches LONG_CYCLES

Behaviour:
- Reset:
  - i_RST_N low immediately clears all synchroniser flops, counters and the long-fired flag.
  - FSM returns to RELEASED; all outputs go to 0.
  - Deassertion takes effect on the next i_CLK edge.
- Synchroniser:
  - Input is polarity-normalised (pressed = 1), then passed through SYNC_STAGES flops; result is s.
  - All FSM decisions use s, never i_btn.
- Counters:
  - Stability counter width is $clog2(DEBOUNCE_CYCLES).
  - Hold counter width is $clog2(max(LONG_CYCLES, REPEAT_CYCLES)).
  - Both are unsigned and never wrap; the hold counter saturates.
- FSM: RELEASED, PRESS_CHK, HELD, RELEASE_CHK.
  - RELEASED:
    - s=1 → PRESS_CHK, cnt=0.
  - PRESS_CHK:
    - s=0 → RELEASED, no output (bounce rejected).
    - s=1 and cnt==DEBOUNCE_CYCLES-1 → HELD; o_press=1 for one cycle; o_level=1; hold_cnt=0; long_fired=0.
    - Otherwise cnt++.
  - HELD:
    - s=0 → RELEASE_CHK, cnt=0; hold_cnt frozen.
    - Otherwise hold_cnt increments, saturating at LONG_CYCLES-1.
    - When hold_cnt==LONG_CYCLES-1 and long_fired=0 → o_long=1 for one cycle; long_fired=1.
  - RELEASE_CHK:
    - s=1 → HELD; hold_cnt and long_fired are retained; no new o_press.
    - s=0 and cnt==DEBOUNCE_CYCLES-1 → RELEASED; o_release=1 for one cycle; o_level=0.
    - Otherwise cnt++.
- Latency:
  - o_press asserts in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES+1, counted from the first edge sampling a steady pressed input.
  - o_release has identical latency for a steady released input.
  - o_long follows o_press by exactly LONG_CYCLES cycles when no release glitch occurs.
- Outputs are registered.
- o_press, o_release and o_long are mutually exclusive in any cycle; o_long and o_press never coincide.
- o_level is 1 exactly in HELD and RELEASE_CHK.
- Button held through reset deassertion is detected as a fresh press with the normal latency.

Optional Feature:
- Macro: BTN_DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - After o_long fires, while in HELD, o_press re-pulses every REPEAT_CYCLES cycles.
  - The first repeat pulse comes REPEAT_CYCLES cycles after o_long.
  - Repeat timer reuses hold_cnt (reset to 0 on each pulse) and pauses in RELEASE_CHK.
  - Release ends repeating.
- Undefined:
  - Exactly one o_press per accepted press.
  - REPEAT_CYCLES is unused; no repeat logic is synthesised.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3, IN_ACTIVE_LOW=0; i_btn rises before edge 1.
1. i_btn held high 30 cycles → o_press=1 only after edge 7; o_level=1 from edge 7; o_long=1 only after edge 17; o_release never.
2. i_btn high for edges 1-3 then low → o_press, o_level, o_long stay 0 throughout.
3. Press accepted, then i_btn low steady from edge 20 → o_release one-cycle pulse after edge 27; o_level=0 from edge 27.
4. Press accepted, i_btn low for 2 cycles at edge 12 then high → no o_release, no second o_press, o_level stays 1; o_long still fires once.
5. i_RST_N pulsed low mid-cycle at edge 10 with i_btn held high → all outputs 0 asynchronously; after release at edge 12, o_press fires after edge 19.
6. With BTN_DEBOUNCE_AUTOREPEAT_EN and i_btn held 40 cycles → o_press after edges 7, 20, 23, 26, …; o_long after edge 17.
